// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one raster-ordered frame from memory through a
// PIPE_LAT-deep datapath with back-pressure, drains it, and writes results back.
module frame_sequencer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int PIXEL_SIZE = 24,
  parameter int ADDR_W     = 20,
  parameter int OUT_BASE   = 307200,
  parameter int PIPE_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIXEL_SIZE-1:0] rd_data,
  output logic                  dp_en,
  output logic                  dp_valid,
  output logic [PIXEL_SIZE-1:0] dp_data,
  output logic                  dp_sol,
  output logic                  dp_sof,
  input  logic [PIXEL_SIZE-1:0] dp_out,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PIXEL_SIZE-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Handshake: start is taken only in IDLE; stall is the single ready input and
  // freezes every advance; dp_en and wr_en are the transfer strobes, never asserted while stalled.

  localparam int N     = WIDTH * HEIGHT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam int X_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DR_W  = $clog2(PIPE_LAT + 1);

  localparam logic [CNT_W-1:0]  N_C        = CNT_W'(N);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N - 1);
  localparam logic [X_W-1:0]    X_LAST     = X_W'(WIDTH - 1);
  localparam logic [DR_W-1:0]   DR_LAST    = DR_W'(PIPE_LAT - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE_C = ADDR_W'(OUT_BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]      f_q;
  logic [IDX_W-1:0]      feed_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [DR_W-1:0]       drain_q;
  logic                  ret_vld_q;
  logic                  skid_vld_q;
  logic [PIXEL_SIZE-1:0] skid_data_q;
  logic                  pipe_vld_q [PIPE_LAT];
  logic [IDX_W-1:0]      pipe_idx_q [PIPE_LAT];

  logic skid_full;
  logic ret_taken;
  logic frame_start;

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    dp_en     = 1'b0;
    dp_valid  = 1'b0;
    dp_data   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    skid_full = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        dp_en    = (skid_vld_q | ret_vld_q) & ~stall;
        dp_valid = dp_en;
        // The held skid pixel is older than anything returning this cycle.
        if (dp_en) dp_data = skid_vld_q ? skid_data_q : rd_data;
        skid_full = skid_vld_q & ~dp_en;
        rd_en     = (f_q < N_C) & ~stall & ~skid_full;
        if (dp_en && (feed_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy  = 1'b1;
        dp_en = ~stall;
        if (dp_en && (drain_q == DR_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_start = (state_q == S_IDLE) & start;
  assign ret_taken   = dp_en & ~skid_vld_q;

  assign rd_addr   = rd_en ? ADDR_W'(f_q) : '0;
  assign dp_sol    = dp_valid & (x_q == '0);
  assign dp_sof    = dp_sol & (y_q == '0);
  assign wr_en     = dp_en & pipe_vld_q[PIPE_LAT-1];
  assign wr_addr   = wr_en ? (OUT_BASE_C + ADDR_W'(pipe_idx_q[PIPE_LAT-1])) : '0;
  // Result is forwarded only while it is being written, so the bus idles at 0.
  assign wr_data   = wr_en ? dp_out : '0;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q       <= '0;
      feed_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      drain_q   <= '0;
      ret_vld_q <= 1'b0;
    end else begin
      ret_vld_q <= rd_en;
      if (frame_start) begin
        f_q     <= '0;
        feed_q  <= '0;
        x_q     <= '0;
        y_q     <= '0;
        drain_q <= '0;
      end else begin
        if (rd_en) f_q <= f_q + CNT_W'(1);
        if (dp_valid) begin
          feed_q <= feed_q + IDX_W'(1);
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + Y_W'(1);
          end else begin
            x_q <= x_q + X_W'(1);
          end
        end
        if ((state_q == S_DRAIN) && dp_en) drain_q <= drain_q + DR_W'(1);
      end
    end
  end

  // Return data that cannot be fed this cycle is parked, never dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else if (ret_vld_q && !ret_taken) begin
      skid_vld_q  <= 1'b1;
      skid_data_q <= rd_data;
    end else if (dp_en && skid_vld_q) begin
      skid_vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_idx_q[i] <= '0;
      end
    end else if (dp_en) begin
      pipe_vld_q[0] <= dp_valid;
      pipe_idx_q[0] <= feed_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: memory and datapath models, a transaction-level
// reference model checked every cycle, and directed plus randomized frames.
module tb_frame_sequencer;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int PS  = 8;
  localparam int AW  = 6;
  localparam int OB  = 16;
  localparam int LAT = 2;
  localparam int N   = W * H;

  logic          clk, reset, start, stall;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PS-1:0] rd_data;
  logic          dp_en, dp_valid, dp_sol, dp_sof;
  logic [PS-1:0] dp_data, dp_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PS-1:0] wr_data;
  logic          busy, done;
  logic [1:0]    dbg_state;

  frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS), .ADDR_W(AW), .OUT_BASE(OB), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dp_en(dp_en), .dp_valid(dp_valid), .dp_data(dp_data),
    .dp_sol(dp_sol), .dp_sof(dp_sof), .dp_out(dp_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory and datapath models ----------------
  logic [PS-1:0] init_mem [N];
  logic [PS-1:0] out_mem  [N];
  logic          clr_out = 1'b0;
  logic [PS-1:0] dp_st    [LAT];

  always @(posedge clk) begin
    if (rd_en) rd_data <= init_mem[rd_addr[2:0]];
    if (clr_out) begin
      for (int i = 0; i < N; i++) out_mem[i] <= '0;
    end else if (wr_en && (wr_addr >= AW'(OB)) && (wr_addr < AW'(OB + N))) begin
      out_mem[3'(wr_addr - AW'(OB))] <= wr_data;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) dp_st[i] <= '0;
    end else if (dp_en) begin
      dp_st[0] <= dp_data + 8'd1;
      for (int i = 1; i < LAT; i++) dp_st[i] <= dp_st[i-1];
    end
  end
  assign dp_out = dp_st[LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: reads issued, pixels fed, datapath advances, writes done.
  logic [PS-1:0] exp_q [$];
  int  m_reads = 0, m_fed = 0, m_adv = 0, m_wrc = 0;
  bit  m_in_frame = 0, m_done_next = 0;

  // Per-frame observations used by the literal checks.
  bit  done_seen;
  int  done_cyc, n_done_frame, first_rd, first_wr, first_dpen, last_dpv, n_dpen, n_wr;
  int  sol_cyc [$];
  int  sof_cyc [$];
  int  frame_t0;

  always @(negedge clk) begin : compare_p
    bit e_rd, e_val, e_en, e_wr, cur_done, idle_now, fetching, draining;
    int pending;
    logic [PS-1:0] exp_d;
    if (reset) begin
      check("rst_rd_en",    32'(rd_en),    0);
      check("rst_rd_addr",  32'(rd_addr),  0);
      check("rst_dp_en",    32'(dp_en),    0);
      check("rst_dp_valid", 32'(dp_valid), 0);
      check("rst_dp_data",  32'(dp_data),  0);
      check("rst_dp_sol",   32'(dp_sol),   0);
      check("rst_dp_sof",   32'(dp_sof),   0);
      check("rst_wr_en",    32'(wr_en),    0);
      check("rst_wr_addr",  32'(wr_addr),  0);
      check("rst_wr_data",  32'(wr_data),  0);
      check("rst_busy",     32'(busy),     0);
      check("rst_done",     32'(done),     0);
      m_in_frame = 0; m_done_next = 0;
      m_reads = 0; m_fed = 0; m_adv = 0; m_wrc = 0;
      exp_q.delete();
    end else begin
      cur_done = m_done_next;
      idle_now = !m_in_frame && !cur_done;
      fetching = m_in_frame && (m_fed < N);
      draining = m_in_frame && (m_fed == N) && (m_adv < N + LAT);
      pending  = m_reads - m_fed;
      e_rd  = fetching && (m_reads < N) && !stall;
      e_val = fetching && (pending > 0) && !stall;
      e_en  = e_val || (draining && !stall);
      e_wr  = e_en && (m_adv >= LAT);

      check("rd_en",    32'(rd_en),    32'(e_rd));
      check("dp_en",    32'(dp_en),    32'(e_en));
      check("dp_valid", 32'(dp_valid), 32'(e_val));
      check("wr_en",    32'(wr_en),    32'(e_wr));
      check("busy",     32'(busy),     32'(m_in_frame));
      check("done",     32'(done),     32'(cur_done));

      if (rd_en && e_rd) check("rd_addr", 32'(rd_addr), m_reads);
      if (dp_valid && e_val) begin
        exp_d = exp_q.pop_front();
        check("dp_data", 32'(dp_data), 32'(exp_d));
        check("dp_sol",  32'(dp_sol),  32'((m_fed % W) == 0));
        check("dp_sof",  32'(dp_sof),  32'(m_fed == 0));
      end else if (!dp_valid) begin
        check("dp_data_idle", 32'(dp_data), 0);
        check("dp_sol_idle",  32'(dp_sol),  0);
        check("dp_sof_idle",  32'(dp_sof),  0);
      end
      if (wr_en && e_wr) begin
        exp_d = init_mem[m_wrc] + 8'd1;
        check("wr_addr", 32'(wr_addr), OB + m_wrc);
        check("wr_data", 32'(wr_data), 32'(exp_d));
      end

      if (done) begin done_seen = 1; done_cyc = cyc; n_done_frame++; end
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (wr_en && first_wr < 0) first_wr = cyc;
      if (dp_en && first_dpen < 0) first_dpen = cyc;
      if (dp_valid) last_dpv = cyc;
      if (dp_en) n_dpen++;
      if (wr_en) n_wr++;
      if (dp_sol) sol_cyc.push_back(cyc);
      if (dp_sof) sof_cyc.push_back(cyc);

      m_done_next = 0;
      if (e_rd) begin
        exp_q.push_back(init_mem[m_reads]);
        m_reads++;
      end
      if (e_val) m_fed++;
      if (e_en) begin
        m_adv++;
        if (e_wr) m_wrc++;
        if (m_adv == N + LAT) begin
          m_in_frame  = 0;
          m_done_next = 1;
        end
      end
      if (start && idle_now) begin
        m_in_frame = 1;
        m_reads = 0; m_fed = 0; m_adv = 0; m_wrc = 0;
        exp_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 1 plain, 2 stall at 4-5, 3 restart at 5, 4 reset(+start) at 6,
  // 5 stall held 10 cycles in drain, 6 random stall/start.
  task automatic do_frame(input int kind, output int dcyc);
    int hold;
    int rel;
    clr_out = 1'b1;
    step();
    clr_out = 1'b0;
    done_seen = 0; done_cyc = -1; n_done_frame = 0;
    first_rd = -1; first_wr = -1; first_dpen = -1; last_dpv = -1;
    n_dpen = 0; n_wr = 0;
    sol_cyc.delete(); sof_cyc.delete();
    start = 1'b1;
    frame_t0 = cyc;
    hold = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      rel = cyc - frame_t0;
      if (done_seen || (kind == 4 && rel == 8)) break;
      start = 1'b0; stall = 1'b0; reset = 1'b0;
      case (kind)
        2: stall = (rel == 4 || rel == 5);
        3: start = (rel == 5);
        4: if (rel == 6) begin reset = 1'b1; start = 1'b1; end
        5: if (m_in_frame && m_fed == N && hold < 10) begin stall = 1'b1; hold++; end
        6: begin
          stall = ($urandom_range(0, 3) == 0);
          start = ($urandom_range(0, 7) == 0);
        end
        default: ;
      endcase
    end
    start = 1'b0; stall = 1'b0; reset = 1'b0;
    dcyc = done_seen ? (done_cyc - frame_t0) : -1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) init_mem[i] = 8'(i);
  endtask

  task automatic check_out_ramp(input string name);
    for (int i = 0; i < N; i++) check(name, 32'(out_mem[i]), i + 1);
  endtask

  // ---------------- stimulus and final report ----------------
  initial begin
    int d;
    logic [PS-1:0] e;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    load_ramp();
    repeat (3) step();
    reset = 1'b0;
    step();

    // Plain frame with the ramp image.
    do_frame(1, d);
    check("s1_done_cycle",  d, 12);
    check("s1_first_rd",    first_rd - frame_t0, 1);
    check("s1_first_dpen",  first_dpen - frame_t0, 2);
    check("s1_last_dpv",    last_dpv - frame_t0, 9);
    check("s1_n_dpen",      n_dpen, 10);
    check("s1_first_wr",    first_wr - frame_t0, 4);
    check("s1_n_wr",        n_wr, 8);
    check("s1_n_sol",       sol_cyc.size(), 2);
    check("s1_sol0",        (sol_cyc.size() > 0) ? sol_cyc[0] - frame_t0 : -1, 2);
    check("s1_sol1",        (sol_cyc.size() > 1) ? sol_cyc[1] - frame_t0 : -1, 6);
    check("s1_n_sof",       sof_cyc.size(), 1);
    check("s1_sof0",        (sof_cyc.size() > 0) ? sof_cyc[0] - frame_t0 : -1, 2);
    check_out_ramp("s1_mem");

    // Two-cycle stall while a read is in flight.
    do_frame(2, d);
    check("s2_done_cycle", d, 14);
    check("s2_first_wr",   first_wr - frame_t0, 6);
    check("s2_n_wr",       n_wr, 8);
    check_out_ramp("s2_mem");

    // Second start while busy.
    do_frame(3, d);
    check("s3_done_cycle", d, 12);
    repeat (3) step();
    check("s3_n_done",     n_done_frame, 1);
    check("s3_n_wr",       n_wr, 8);
    check_out_ramp("s3_mem");

    // Reset mid-frame (with a simultaneous start), then a fresh frame.
    do_frame(4, d);
    repeat (3) step();
    check("s4_n_done",     n_done_frame, 0);
    check("s4_n_wr",       n_wr, 2);
    do_frame(1, d);
    check("s4_restart_done", d, 12);
    check("s4_restart_n_wr", n_wr, 8);
    check_out_ramp("s4_mem");

    // Stall held through the drain.
    do_frame(5, d);
    check("s5_done_cycle", d, 22);
    check("s5_n_wr",       n_wr, 8);
    check_out_ramp("s5_mem");

    // Random images, random back-pressure and stray starts.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) init_mem[i] = 8'($urandom_range(0, 255));
      do_frame(6, d);
      check("s6_done_seen", 32'(done_seen), 1);
      check("s6_n_wr",      n_wr, 8);
      for (int i = 0; i < N; i++) begin
        e = init_mem[i] + 8'd1;
        check("s6_mem", 32'(out_mem[i]), 32'(e));
      end
      repeat (2) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Controller that sequences one bitmap frame through the pixel datapath.
- Fetches raster-ordered pixels from frame memory and drives the datapath enable and data inputs.
- Tracks datapath latency and writes each result back to an output region of the same memory.
- Replaces the free-running pixel feed: gives the datapath a start/done handshake, back-pressure and an explicit pipeline drain.

Parameters:
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines per frame.
- PIXEL_SIZE, 24: pixel width in bits.
- ADDR_W, 20: memory address width; must satisfy 2^ADDR_W > OUT_BASE + WIDTH*HEIGHT - 1.
- OUT_BASE, 307200: word address of output pixel 0.
- PIPE_LAT, 3: datapath latency in advances (dp_en-high cycles); must be 1 or more.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to process a frame; ignored unless IDLE.
- stall  in  1  downstream back-pressure; freezes fetch and datapath advance.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  read address; data returns the next cycle.
- rd_data  in  PIXEL_SIZE  read data, valid one cycle after rd_en.
- dp_en  out  1  datapath advance; the datapath moves one stage only when high.
- dp_valid  out  1  dp_data is a real pixel (low during drain).
- dp_data  out  PIXEL_SIZE  pixel to the datapath; 0 when dp_valid is low.
- dp_sol  out  1  dp_data is the first pixel of a line (x==0).
- dp_sof  out  1  dp_data is pixel 0 of the frame.
- dp_out  in  PIXEL_SIZE  datapath result for the item fed PIPE_LAT advances earlier.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  OUT_BASE + index of the pixel being written.
- wr_data  out  PIXEL_SIZE  equals dp_out.
- busy  out  1  high in FETCH or DRAIN.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset: state=IDLE; fetch and feed counters, x, y, skid buffer and valid shift register all cleared.
- Reset values of outputs: rd_en, rd_addr, dp_*, wr_*, busy and done all 0.
- Reset asserted mid-frame aborts the frame immediately, with no done pulse and no further writes.
- N = WIDTH*HEIGHT. Fetch index f runs 0..N-1; rd_addr=f. Feed x/y counters wrap x at WIDTH-1 and increment y.
- States: IDLE -> FETCH on start.
- FETCH -> DRAIN in the cycle after the last pixel (index N-1) is fed with dp_en high.
- DRAIN -> DONE after PIPE_LAT further advances.
- DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
- FETCH read rule: rd_en = (f<N) & ~stall & ~skid_full; f increments on each rd_en.
- Returned data: a read issued in cycle t has its data arrive in t+1. If stall is high in t+1, the data goes into a one-entry skid register; it is never dropped.
- FETCH feed rule: dp_en = (skid_valid | rd_ret_valid) & ~stall. The skid entry is fed before new return data.
- dp_valid=1 when fed from either source; dp_sol and dp_sof decode from the feed x/y counters.
- DRAIN: dp_en=~stall, dp_valid=0, dp_data=0.
- Write-back: a PIPE_LAT-deep shift register of (valid, index) advances only on dp_en.
- wr_en = dp_en & tail_valid, combinational in the same cycle; wr_addr = OUT_BASE + tail_index; wr_data = dp_out.
- stall=1: dp_en=0 and wr_en=0; counters hold except the skid capture.
- start while busy is ignored.
- start in the same cycle as reset is ignored.
- Exactly N writes occur per frame, in ascending address order.

Test Plan:
- WIDTH=4, HEIGHT=2, PIPE_LAT=2, OUT_BASE=16, start at cycle 0, no stall -> rd_en cycles 1-8 at addr 0-7; dp_en cycles 2-11; dp_valid 2-9; dp_sol at cycles 2 and 6; dp_sof at cycle 2; wr_en cycles 4-11 at addr 16-23; done at cycle 12.
- Same setup with stall high for cycles 4-5 -> no dp_en or wr_en in 4-5; the pixel returned in cycle 4 is held in skid and fed at cycle 6; writes 16-23 each occur once, in order; done at cycle 14.
- Datapath model dp_out = data+1 delayed 2 advances, memory[i]=i -> memory[16+i]=i+1 for i=0..7.
- start pulsed again at cycle 5 -> ignored; the same 8 writes occur; exactly one done pulse.
- Reset asserted at cycle 6 -> all outputs 0 asynchronously; no writes after cycle 6; a fresh start then completes a full frame normally.
- stall held high continuously through DRAIN for 10 cycles -> state holds in DRAIN; on release, the remaining writes complete and done follows.
